mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-access stage that sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Consumes the registered ALU result (address), store data, strobes and control; runs a request/grant/response handshake with data memory.
- Sign/zero-extends load data and presents writeback data, destination and write-enable to MEM/WB.
- Drives a stall to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.

Parameters:
- XLEN, 32, datapath and address width.
- TIMEOUT, 255, max cycles waiting for dmem_gnt/dmem_rvalid before bus error; 0 disables the timeout. Counter width is clog2(TIMEOUT+1), minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- G_in  in  XLEN  ALU result: effective address or non-memory result
- Data_out_in  in  XLEN  store data, already lane-aligned by EX
- STRB_in  in  4  store byte strobes, already aligned
- MD_in  in  1  instruction is a load
- MW_in  in  1  instruction is a store
- RW_in  in  1  register write enable
- RD_in  in  5  destination register
- funct3_in  in  3  access size/sign
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  word address {G_in[XLEN-1:2],2'b00}
- dmem_wdata  out  XLEN  equals Data_out_in
- dmem_wstrb  out  4  equals STRB_in on stores, 0 on loads
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response/ack valid
- dmem_rdata  in  XLEN  load word
- stall_out  out  1  freeze upstream stages
- wb_data  out  XLEN  writeback value
- wb_rd  out  5  equals RD_in
- wb_we  out  1  writeback enable
- misalign_out  out  1  misaligned access, one cycle
- bus_err_out  out  1  timeout abort, one cycle

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset: state=IDLE, counter=0, captured data=0. With state=IDLE and no memory op, all outputs are 0 except pass-through fields.
- IDLE, no MD_in/MW_in: stall_out=0, wb_data=G_in, wb_we=RW_in, wb_rd=RD_in. Same cycle, no bus activity.
- IDLE, MD_in|MW_in, misaligned: no request issued.
  - Misaligned means halfword with G_in[0]=1, or word with G_in[1:0]≠0.
  - Outputs: misalign_out=1, wb_we=0, stall_out=0.
- IDLE, MD_in|MW_in, aligned: go to REQ. stall_out=1 combinationally from that cycle.
- REQ: dmem_req=1 and stable until dmem_gnt.
  - gnt with rvalid in the same cycle: go to DONE and capture rdata.
  - gnt alone: go to WAIT.
- WAIT: dmem_req=0. On dmem_rvalid, capture dmem_rdata and go to DONE.
- Counter: cleared on entering REQ and on gnt; increments each REQ/WAIT cycle. On reaching TIMEOUT (TIMEOUT≠0): bus_err_out=1 for one cycle, go to DONE with wb_we forced 0.
- DONE: exactly one cycle; stall_out=0, so EX/MEM loads the next instruction at this edge. Then return to IDLE.
  - Loads: wb_we=RW_in, wb_data=extended capture.
  - Stores: wb_we=0.
- stall_out=1 in REQ and WAIT, 0 in IDLE(not starting) and DONE. Minimum load/store latency is 2 cycles (REQ with gnt+rvalid, then DONE).
- Load extension uses offset G_in[1:0]:
  - LB 000: byte at offset, sign-extended. LBU 100: zero-extended.
  - LH 001: halfword at offset[1], sign-extended. LHU 101: zero-extended.
  - LW 010: full word.
  - Other funct3 codes: treat as LW.
- dmem_rvalid or dmem_gnt in IDLE/DONE is ignored.
- MD_in and MW_in both set: treat as store.
- Asynchronous reset mid-access: immediately IDLE, dmem_req=0, stall_out=0. A late rvalid afterwards is ignored.
- Inputs are assumed stable while stall_out=1; EX/MEM is frozen by stall_out.

Decomposition:
- Shared package (riscv_pkg) holds:
  - funct3 load/store encodings F3_B/H/W/BU/HU;
  - FSM state enum LSU_IDLE/REQ/WAIT/DONE;
  - strobe constants.
- One combinational sub-module, load_extend (funct3, offset, word -> XLEN result), reused later by any cache path.

Test Plan:
- ALU op: G_in=0x1234, RW_in=1, RD=5, no MD/MW -> wb_data=0x1234, wb_we=1, stall_out=0, dmem_req never 1.
- LB, addr 0x103, rdata 0x80FF_0000, gnt+rvalid in first REQ cycle -> dmem_addr=0x100, stall 1 for 1 cycle, DONE wb_data=0xFFFFFF80, wb_we=1.
- LHU, addr 0x202, gnt after 2 cycles, rvalid 3 cycles later, rdata 0xBEEF_0000 -> req held 3 cycles, stall 6 cycles, wb_data=0x0000BEEF.
- SW, addr 0x40, data 0xDEADBEEF, STRB 1111 -> dmem_we=1, wstrb=1111, wdata=0xDEADBEEF, wb_we=0 in DONE.
- LW, addr 0x6 -> misalign_out=1 one cycle, dmem_req=0, wb_we=0, stall_out=0.
- TIMEOUT=4, gnt never asserted -> bus_err_out=1 after 4 REQ cycles, then DONE, wb_we=0. Separate run: reset asserted during WAIT -> stall_out and dmem_req drop same cycle; later rvalid ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared load/store encodings, LSU state type and strobe constants
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_ALL  = 4'b1111;
  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE} lsu_state_e;
  // size code 00 = byte, 01 = halfword, anything else is treated as a word
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'b00) ? 1'b0 : (sz == 2'b01) ? off[0] : (off != 2'b00);
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword of a load word and sign/zero-extends it
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] result_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word_i[{offset_i, 3'b000} +: 8];
  assign h = word_i[{offset_i[1], 4'b0000} +: 16];
  assign result_o = (funct3_i == F3_B)  ? {{(XLEN-8){b[7]}}, b} :
                    (funct3_i == F3_BU) ? {{(XLEN-8){1'b0}}, b} :
                    (funct3_i == F3_H)  ? {{(XLEN-16){h[15]}}, h} :
                    (funct3_i == F3_HU) ? {{(XLEN-16){1'b0}}, h} : word_i;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage running the dmem req/gnt/rvalid handshake, stalling upstream and producing writeback
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] G_in,
  input  logic [XLEN-1:0] Data_out_in,
  input  logic [3:0]      STRB_in,
  input  logic            MD_in,
  input  logic            MW_in,
  input  logic            RW_in,
  input  logic [4:0]      RD_in,
  input  logic [2:0]      funct3_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_out,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            misalign_out,
  output logic            bus_err_out
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  lsu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            idle, done, mem_op, is_load, mis, start, tmo;
  logic [XLEN-1:0] ext;
  assign idle    = (state_q == LSU_IDLE);
  assign done    = (state_q == LSU_DONE);
  assign mem_op  = MD_in | MW_in;
  assign is_load = MD_in & ~MW_in;
  assign mis     = misaligned(funct3_in[1:0], G_in[1:0]);
  // reset gates the start term so stall drops while reset is held, even with a memory op present
  assign start   = idle & reset & mem_op & ~mis;
  assign tmo     = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  load_extend #(.XLEN(XLEN)) u_ext (
    .funct3_i (funct3_in),
    .offset_i (G_in[1:0]),
    .word_i   (rdata_q),
    .result_o (ext)
  );
  // next state, wait counter, response capture and timeout abort
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    bus_err_out = 1'b0;
    case (state_q)
      LSU_IDLE: if (start) begin
        state_d = LSU_REQ;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      LSU_REQ: if (dmem_gnt && dmem_rvalid) begin
        state_d = LSU_DONE;
        rdata_d = dmem_rdata;
      end else if (dmem_gnt) begin
        state_d = LSU_WAIT;
        cnt_d   = '0;
      end else if (tmo) begin
        state_d     = LSU_DONE;
        err_d       = 1'b1;
        bus_err_out = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      LSU_WAIT: if (dmem_rvalid) begin
        state_d = LSU_DONE;
        rdata_d = dmem_rdata;
      end else if (tmo) begin
        state_d     = LSU_DONE;
        err_d       = 1'b1;
        bus_err_out = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = LSU_IDLE;
    endcase
  end
  // state registers, cleared asynchronously so an abandoned access drops at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign dmem_req     = (state_q == LSU_REQ);
  assign dmem_we      = dmem_req & MW_in;
  assign dmem_wstrb   = dmem_we ? STRB_in : STRB_NONE;
  assign dmem_addr    = {G_in[XLEN-1:2], 2'b00};
  assign dmem_wdata   = Data_out_in;
  assign stall_out    = start | dmem_req | (state_q == LSU_WAIT);
  assign misalign_out = idle & reset & mem_op & mis;
  assign wb_rd        = RD_in;
  assign wb_data      = done ? ext : G_in;
  assign wb_we        = idle ? (RW_in & ~mem_op) : done ? (RW_in & is_load & ~err_q) : 1'b0;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed transactions against a transaction-level timeline and extension model
module tb_mem_stage_lsu;
  localparam int XLEN = 32;
  localparam int TO   = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] G_in = '0, Data_out_in = '0, dmem_rdata = '0;
  logic [3:0]  STRB_in = '0;
  logic        MD_in = 1'b0, MW_in = 1'b0, RW_in = 1'b0, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [4:0]  RD_in = '0;
  logic [2:0]  funct3_in = '0;
  logic        dmem_req, dmem_we, stall_out, wb_we, misalign_out, bus_err_out;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  wb_rd;
  logic        e_stall, e_req, e_we, e_mis, e_berr, e_wbwe;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata, e_wbdata;
  logic [4:0]  e_rd;
  bit          chk_en = 0, chk_data = 0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .G_in(G_in), .Data_out_in(Data_out_in), .STRB_in(STRB_in),
    .MD_in(MD_in), .MW_in(MW_in), .RW_in(RW_in), .RD_in(RD_in), .funct3_in(funct3_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
    int off;
    logic [31:0] b, h;
    off = int'(addr % 4);
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? b | 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? h | 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit misal_model(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    return (addr % size) != 0;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("stall_out", 32'(stall_out), 32'(e_stall));
    chk("dmem_req", 32'(dmem_req), 32'(e_req));
    chk("dmem_we", 32'(dmem_we), 32'(e_we));
    chk("dmem_wstrb", 32'(dmem_wstrb), 32'(e_wstrb));
    chk("dmem_addr", dmem_addr, e_addr);
    chk("dmem_wdata", dmem_wdata, e_wdata);
    chk("wb_rd", 32'(wb_rd), 32'(e_rd));
    chk("wb_we", 32'(wb_we), 32'(e_wbwe));
    chk("misalign_out", 32'(misalign_out), 32'(e_mis));
    chk("bus_err_out", 32'(bus_err_out), 32'(e_berr));
    if (chk_data) chk("wb_data", wb_data, e_wbdata);
  end

  task automatic alu(input logic [31:0] g, input logic rw, input logic [4:0] rd, input logic [31:0] lit, input bit use_lit);
    @(posedge clk); #1;
    G_in = g; RW_in = rw; RD_in = rd; MD_in = 0; MW_in = 0; dmem_gnt = 0; dmem_rvalid = 0;
    e_stall = 0; e_req = 0; e_we = 0; e_wstrb = 0; e_addr = g & ~32'h3; e_wdata = Data_out_in;
    e_rd = rd; e_wbwe = rw; e_mis = 0; e_berr = 0; e_wbdata = g; chk_data = 1;
    #1 if (use_lit) chk("lit_alu_wb_data", wb_data, lit);
  endtask

  // g: REQ cycles before the granting one (negative = never granted), r: cycles from gnt to rvalid
  task automatic op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                    input logic md, input logic mw, input logic rw, input logic [4:0] rd, input logic [31:0] rdata,
                    input int g, input int r, input logic [31:0] lit, input bit use_lit, input int lit_req);
    int reqn, nreq;
    logic ld, never;
    ld = md & ~mw; never = (g < 0); reqn = never ? TO : g + 1; nreq = 0;
    @(posedge clk); #1;
    G_in = addr; Data_out_in = wd; STRB_in = strb; MD_in = md; MW_in = mw; RW_in = rw; RD_in = rd;
    funct3_in = f3; dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = ~rdata;
    e_addr = addr & ~32'h3; e_wdata = wd; e_rd = rd; e_berr = 0; e_req = 0; e_we = 0; e_wstrb = 0;
    e_wbwe = 0; e_wbdata = addr; chk_data = 1;
    if (misal_model(f3, addr)) begin
      e_mis = 1; e_stall = 0;
      #1 if (use_lit) chk("lit_misalign", 32'(misalign_out), lit);
      return;
    end
    e_mis = 0; e_stall = 1;
    for (int k = 1; k <= reqn; k++) begin
      @(posedge clk); #1;
      dmem_rdata = rdata;
      dmem_gnt = !never && k == reqn;
      dmem_rvalid = !never && k == reqn && r == 0;
      e_req = 1; e_we = mw; e_wstrb = mw ? strb : 4'b0; e_berr = never && k == reqn; chk_data = 0;
      #1 if (dmem_req) nreq++;
    end
    if (!never) for (int k = 1; k <= r; k++) begin
      @(posedge clk); #1;
      dmem_gnt = 0; dmem_rvalid = (k == r);
      e_req = 0; e_we = 0; e_wstrb = 0; e_berr = 0;
    end
    @(posedge clk); #1;
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h5A5A_A5A5;
    e_req = 0; e_we = 0; e_wstrb = 0; e_berr = 0; e_stall = 0;
    e_wbwe = rw & ld & !never; chk_data = ld & !never; e_wbdata = ext_model(f3, addr, rdata);
    #1;
    if (use_lit) chk("lit_wb_data", wb_data, lit);
    if (lit_req >= 0) chk("lit_req_cycles", 32'(nreq), 32'(lit_req));
  endtask

  initial begin
    MD_in = 1; G_in = 32'h44; funct3_in = 3'b010;
    #12;
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_misalign", 32'(misalign_out), 32'd0);
    chk("rst_bus_err", 32'(bus_err_out), 32'd0);
    MD_in = 0; G_in = 0;
    @(posedge clk); #1 reset = 1;
    e_stall = 0; e_req = 0; e_we = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0; e_rd = 0;
    e_wbwe = 0; e_mis = 0; e_berr = 0; e_wbdata = 0; chk_data = 1; chk_en = 1;
    alu(32'h1234, 1, 5, 32'h1234, 1);
    op(3'b000, 32'h103, 0, 4'h0, 1, 0, 1, 7, 32'h80FF_0000, 0, 0, 32'hFFFF_FF80, 1, 1);
    op(3'b101, 32'h202, 0, 4'h0, 1, 0, 1, 8, 32'hBEEF_0000, 2, 3, 32'h0000_BEEF, 1, 3);
    op(3'b010, 32'h40, 32'hDEAD_BEEF, 4'hF, 0, 1, 0, 0, 0, 1, 1, 0, 0, 2);
    op(3'b010, 32'h6, 0, 4'h0, 1, 0, 1, 3, 0, 0, 0, 32'd1, 1, -1);
    op(3'b001, 32'h101, 0, 4'h0, 1, 0, 1, 4, 0, 0, 0, 32'd1, 1, -1);
    op(3'b001, 32'h2, 0, 4'h0, 1, 0, 1, 9, 32'h8001_7FFF, 0, 1, 32'hFFFF_8001, 1, 1);
    op(3'b100, 32'h1, 0, 4'h0, 1, 0, 1, 10, 32'h0000_9A00, 1, 0, 32'h0000_009A, 1, 2);
    op(3'b010, 32'h10, 0, 4'h0, 1, 0, 1, 11, 32'h1234_5678, 0, 2, 32'h1234_5678, 1, 1);
    op(3'b011, 32'h20, 0, 4'h0, 1, 0, 1, 12, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 1, 1);
    op(3'b000, 32'h22, 0, 4'h0, 1, 0, 0, 13, 32'h0055_0000, 0, 0, 32'h0000_0055, 1, 1);
    op(3'b010, 32'h44, 32'h0BAD_F00D, 4'hF, 1, 1, 1, 14, 0, 0, 0, 0, 0, 1);
    op(3'b001, 32'h12, 32'h0000_AB00, 4'hC, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    op(3'b010, 32'h30, 0, 4'h0, 1, 0, 1, 15, 32'h7777_7777, -1, 0, 0, 0, TO);
    alu(32'hFFFF_0001, 0, 31, 0, 0);
    @(posedge clk); #1 chk_en = 0;
    G_in = 32'h50; MD_in = 1; MW_in = 0; RW_in = 1; RD_in = 6; funct3_in = 3'b010; dmem_gnt = 0; dmem_rvalid = 0;
    @(posedge clk); #1 dmem_gnt = 1;
    @(posedge clk); #1 dmem_gnt = 0;
    #1 chk("wait_stall", 32'(stall_out), 32'd1);
    reset = 0;
    #1;
    chk("arst_stall", 32'(stall_out), 32'd0);
    chk("arst_req", 32'(dmem_req), 32'd0);
    MD_in = 0; G_in = 32'h77; RD_in = 9;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("late_rvalid_stall", 32'(stall_out), 32'd0);
    chk("late_rvalid_wb_data", wb_data, 32'h77);
    chk("late_rvalid_wb_we", 32'(wb_we), 32'd1);
    @(posedge clk); #1 dmem_rvalid = 0;
    #1;
    chk("post_rvalid_stall", 32'(stall_out), 32'd0);
    chk("post_rvalid_wb_data", wb_data, 32'h77);
    chk("post_rvalid_req", 32'(dmem_req), 32'd0);
    alu(32'h0000_0ACE, 1, 2, 32'h0000_0ACE, 1);
    @(posedge clk); #1 chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
